// File: rtl/stopwatch_up.sv
// Two-digit BCD count-up stopwatch (00-99) with start/stop, lap-hold and clear.
// Every output is a flop loaded from the next-state values, so no input reaches an output combinationally.
`timescale 1ns/1ps
module stopwatch_up #(
  parameter int unsigned TICK_FACTOR = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       lap_active,
  output logic       overflow,
  output logic       sec_tick
);

  localparam int unsigned PW = (TICK_FACTOR > 1) ? $clog2(TICK_FACTOR) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_FACTOR - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  typedef enum logic [1:0] {STOPPED, RUNNING, LAP_HOLD, PAUSED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    live_t_q, live_o_q, lap_t_q, lap_o_q;
  logic [3:0]    live_t_d, live_o_d, lap_t_d, lap_o_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          ovf_d, tick, advance;
  logic [3:0]    disp_t_d, disp_o_d;

  always_comb begin
    state_d  = state_q;
    live_t_d = live_t_q;
    live_o_d = live_o_q;
    lap_t_d  = lap_t_q;
    lap_o_d  = lap_o_q;
    pre_d    = pre_q;
    ovf_d    = overflow;
    tick     = 1'b0;

    // The resume edge also advances the prescaler, so a paused partial second
    // finishes TICK_FACTOR-1-p edges after resuming.
    advance = (state_q == RUNNING) || (state_q == LAP_HOLD) ||
              ((state_q == PAUSED) && start_stop && !clear);

    if (advance) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
        if (live_o_q == 4'd9) begin
          live_o_d = '0;
          if (live_t_q == 4'd9) begin
            live_t_d = '0;
            ovf_d    = 1'b1;
          end else begin
            live_t_d = live_t_q + 4'd1;
          end
        end else begin
          live_o_d = live_o_q + 4'd1;
        end
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end

    case (state_q)
      STOPPED: begin
        if (clear) begin
          live_t_d = '0;
          live_o_d = '0;
          ovf_d    = 1'b0;
        end else if (start_stop) begin
          state_d = RUNNING;
          pre_d   = '0;
        end
      end
      RUNNING: begin
        if (start_stop) begin
          state_d = PAUSED;
        end else if (lap) begin
          state_d = LAP_HOLD;
          lap_t_d = live_t_d;
          lap_o_d = live_o_d;
        end
      end
      LAP_HOLD: begin
        if (start_stop) begin
          state_d = PAUSED;
        end else if (lap) begin
          state_d = RUNNING;
        end
      end
      PAUSED: begin
        if (clear) begin
          state_d  = STOPPED;
          live_t_d = '0;
          live_o_d = '0;
          pre_d    = '0;
          ovf_d    = 1'b0;
        end else if (start_stop) begin
          state_d = RUNNING;
        end
      end
      default: state_d = STOPPED;
    endcase

    disp_t_d = (state_d == LAP_HOLD) ? lap_t_d : live_t_d;
    disp_o_d = (state_d == LAP_HOLD) ? lap_o_d : live_o_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= STOPPED;
      live_t_q   <= '0;
      live_o_q   <= '0;
      lap_t_q    <= '0;
      lap_o_q    <= '0;
      pre_q      <= '0;
      tens       <= '0;
      ones       <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      sec_tick   <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_t_q   <= live_t_d;
      live_o_q   <= live_o_d;
      lap_t_q    <= lap_t_d;
      lap_o_q    <= lap_o_d;
      pre_q      <= pre_d;
      tens       <= disp_t_d;
      ones       <= disp_o_d;
      running    <= (state_d == RUNNING) || (state_d == LAP_HOLD);
      lap_active <= (state_d == LAP_HOLD);
      overflow   <= ovf_d;
      sec_tick   <= tick;
    end
  end

endmodule

// File: tb/tb_stopwatch_up.sv
// Bench for stopwatch_up: decimal elapsed-time model checked every cycle,
// plus hand-computed literal checkpoints along a directed scenario.
`timescale 1ns/1ps
module tb_stopwatch_up;

  localparam int unsigned TF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] tens, ones;
  logic       running, lap_active, overflow, sec_tick;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  stopwatch_up #(.TICK_FACTOR(TF)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .tens       (tens),
    .ones       (ones),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  // Model: elapsed seconds as a plain integer, run/hold/stopped flags,
  // and the number of counting edges since the last second boundary.
  int m_count, m_lap, m_phase;
  bit m_stopped, m_run, m_hold, m_ovf, m_tick;
  bit chk_en = 1'b0;

  task automatic model_reset();
    m_count = 0; m_lap = 0; m_phase = 0;
    m_stopped = 1'b1; m_run = 1'b0; m_hold = 1'b0; m_ovf = 1'b0; m_tick = 1'b0;
  endtask

  task automatic model_step(input bit ss, input bit lp, input bit clr);
    bit paused;
    paused = !m_stopped && !m_run;
    m_tick = 1'b0;
    if (m_stopped && ss && !clr) begin
      m_phase = 0;
    end else if (m_run || (paused && ss && !clr)) begin
      m_phase++;
      if (m_phase == TF) begin
        m_phase = 0;
        m_tick  = 1'b1;
        m_count = (m_count + 1) % 100;
        if (m_count == 0) m_ovf = 1'b1;
      end
    end
    if (m_stopped) begin
      if (clr) begin
        m_count = 0; m_ovf = 1'b0;
      end else if (ss) begin
        m_stopped = 1'b0; m_run = 1'b1;
      end
    end else if (paused) begin
      if (clr) begin
        m_stopped = 1'b1; m_count = 0; m_phase = 0; m_ovf = 1'b0;
      end else if (ss) begin
        m_run = 1'b1;
      end
    end else begin
      if (ss) begin
        m_run = 1'b0; m_hold = 1'b0;
      end else if (lp) begin
        if (m_hold) m_hold = 1'b0;
        else begin
          m_hold = 1'b1; m_lap = m_count;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("tens",       32'(tens),       32'((m_hold ? m_lap : m_count) / 10));
      check("ones",       32'(ones),       32'((m_hold ? m_lap : m_count) % 10));
      check("running",    32'(running),    32'(m_run));
      check("lap_active", 32'(lap_active), 32'(m_hold));
      check("overflow",   32'(overflow),   32'(m_ovf));
      check("sec_tick",   32'(sec_tick),   32'(m_tick));
    end
  end

  task automatic cycle(input bit ss, input bit lp, input bit clr);
    @(negedge clk);
    start_stop = ss; lap = lp; clear = clr;
    @(posedge clk);
    model_step(ss, lp, clr);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int guard;
    model_reset();
    rst = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle after reset
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0);
      if (sec_tick) ticks++;
    end
    check("idle_ticks", 32'(ticks), 32'd0);
    check("idle_tens", 32'(tens), 32'd0);
    check("idle_running", 32'(running), 32'd0);

    // Basic count: start at E0, ticks at E4..E40
    cycle(1, 0, 0);
    check("start_running", 32'(running), 32'd1);
    ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(0, 0, 0);
      if (sec_tick) ticks++;
      if (i == 3) check("e3_no_tick", 32'(sec_tick), 32'd0);
      if (i == 4) check("e4_tick", 32'(sec_tick), 32'd1);
    end
    check("basic_ticks", 32'(ticks), 32'd10);
    check("e40_tens", 32'(tens), 32'd1);
    check("e40_ones", 32'(ones), 32'd0);
    check("model_e40", 32'(m_count), 32'd10);

    // Pause then clear back to STOPPED
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    check("clr_tens", 32'(tens), 32'd0);
    check("clr_running", 32'(running), 32'd0);

    // Pause/resume with partial second retained
    cycle(1, 0, 0);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("pause_ones", 32'(ones), 32'd1);
    check("pause_running", 32'(running), 32'd0);
    repeat (10) cycle(0, 0, 0);
    check("paused_hold", 32'(ones), 32'd1);
    cycle(1, 0, 0);
    check("resume_no_tick", 32'(sec_tick), 32'd0);
    cycle(0, 0, 0);
    check("resume_tick", 32'(sec_tick), 32'd1);
    check("resume_ones", 32'(ones), 32'd2);

    // Lap hold
    repeat (4) cycle(0, 0, 0);
    check("pre_lap_ones", 32'(ones), 32'd3);
    cycle(0, 1, 0);
    check("lap_active", 32'(lap_active), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0);
      check("lap_hold_ones", 32'(ones), 32'd3);
      check("lap_hold_run", 32'(running), 32'd1);
    end
    cycle(0, 1, 0);
    check("lap_release_ones", 32'(ones), 32'd5);
    check("lap_release_act", 32'(lap_active), 32'd0);
    check("lap_release_run", 32'(running), 32'd1);

    // Count to 99, then wrap
    guard = 0;
    while (m_count != 99 && guard < 500) begin
      cycle(0, 0, 0);
      guard++;
    end
    check("reach_99", 32'(tens * 10 + ones), 32'd99);
    guard = 0;
    do begin
      cycle(0, 0, 0);
      guard++;
    end while (!sec_tick && guard < 2 * TF);
    check("wrap_tick_seen", 32'(sec_tick), 32'd1);
    check("wrap_tens", 32'(tens), 32'd0);
    check("wrap_ones", 32'(ones), 32'd0);
    check("wrap_ovf", 32'(overflow), 32'd1);
    cycle(1, 0, 0);
    check("paused_ovf", 32'(overflow), 32'd1);
    cycle(0, 0, 1);
    check("clear_ovf", 32'(overflow), 32'd0);
    check("clear_running", 32'(running), 32'd0);

    // STOPPED: clear beats start_stop
    cycle(1, 1, 1);
    check("stopped_clr_wins", 32'(running), 32'd0);

    // RUNNING: clear ignored, start_stop pauses
    cycle(1, 0, 0);
    repeat (5) cycle(0, 0, 0);
    cycle(1, 0, 1);
    check("sim_running", 32'(running), 32'd0);
    check("sim_ones", 32'(ones), 32'd1);
    cycle(1, 0, 0);
    guard = 0;
    while (m_phase != TF - 1 && guard < 2 * TF) begin
      cycle(0, 0, 0);
      guard++;
    end
    cycle(1, 0, 0);
    check("tick_pause_tick", 32'(sec_tick), 32'd1);
    check("tick_pause_run", 32'(running), 32'd0);
    check("tick_pause_ones", 32'(ones), 32'd2);

    // Async reset mid-count
    cycle(1, 0, 0);
    repeat (6) cycle(0, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_ones", 32'(ones), 32'd0);
    check("arst_tens", 32'(tens), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_tick", 32'(sec_tick), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 0, 0);
    repeat (4) cycle(0, 0, 0);
    check("post_rst_tick", 32'(sec_tick), 32'd1);
    check("post_rst_ones", 32'(ones), 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
